// File: rtl/li_shell_pkg.sv
// ----------------------------------------------------------------------------
// li_shell_pkg - shared constants and helpers for LI shells (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

package li_shell_pkg;

  localparam int LI_MAX_DEPTH = 16;

  // Occupancy at which an input queue raises stop; one slot stays free for
  // the token that may still arrive in the cycle stop is first seen.
  function automatic int li_stop_thresh(input int depth);
    return depth - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/li_link.sv
// ----------------------------------------------------------------------------
// li_link - latency-insensitive channel: data/valid forward, stop backward (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

interface li_link #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] data;
  logic             valid;
  logic             stop;

  modport source (output data, output valid, input stop);
  modport sink   (input data, input valid, output stop);

endinterface

`default_nettype wire

// File: rtl/li_shell_queue.sv
// ----------------------------------------------------------------------------
// li_shell_queue - input queue of an LI shell with registered stop (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module li_shell_queue
  import li_shell_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  li_link.sink             link,
  output logic [WIDTH-1:0] head,
  output logic             not_empty,
  input  logic             deq,
  output logic             overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] THRESH = CNT_W'(li_stop_thresh(DEPTH));
  localparam logic [PTR_W-1:0] LAST   = PTR_W'(DEPTH - 1);

  generate
    if (DEPTH < 2 || DEPTH > LI_MAX_DEPTH) begin : g_bad_depth
      $error("li_shell_queue: DEPTH out of range");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] next_count;
  logic             enq;
  logic             do_deq;

  assign not_empty = (count != '0);
  assign head      = mem[rd_ptr];

  // A full queue still accepts a token when a dequeue frees a slot in the same cycle.
  always_comb begin
    do_deq     = deq && not_empty;
    enq        = link.valid && ((count != FULL) || do_deq);
    overflow   = link.valid && (count == FULL) && !do_deq;
    next_count = count + CNT_W'(enq) - CNT_W'(do_deq);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      link.stop <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (enq) begin
        mem[wr_ptr] <= link.data;
        wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (do_deq) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      count     <= next_count;
      link.stop <= (next_count >= THRESH);
    end
  end

endmodule

`default_nettype wire

// File: rtl/li_shell_join2.sv
// ----------------------------------------------------------------------------
// li_shell_join2 - LI shell joining two input channels into one pearl firing (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module li_shell_join2
  import li_shell_pkg::*;
#(
  parameter int WIDTH_A   = 6,
  parameter int WIDTH_B   = 6,
  parameter int WIDTH_OUT = 6,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  li_link.sink                 in_a_link,
  li_link.sink                 in_b_link,
  li_link.source               out_link,
  output logic [WIDTH_A-1:0]   pearl_a,
  output logic [WIDTH_B-1:0]   pearl_b,
  output logic                 pearl_en,
  input  logic [WIDTH_OUT-1:0] pearl_result,
  output logic                 err_overflow
);

  logic a_not_empty;
  logic b_not_empty;
  logic a_overflow;
  logic b_overflow;
  logic fire;

  li_shell_queue #(.WIDTH(WIDTH_A), .DEPTH(DEPTH)) u_queue_a (
    .clk       (clk),
    .reset     (reset),
    .link      (in_a_link),
    .head      (pearl_a),
    .not_empty (a_not_empty),
    .deq       (fire),
    .overflow  (a_overflow)
  );

  li_shell_queue #(.WIDTH(WIDTH_B), .DEPTH(DEPTH)) u_queue_b (
    .clk       (clk),
    .reset     (reset),
    .link      (in_b_link),
    .head      (pearl_b),
    .not_empty (b_not_empty),
    .deq       (fire),
    .overflow  (b_overflow)
  );

  assign fire     = a_not_empty && b_not_empty && !out_link.stop;
  assign pearl_en = fire;

  // out_valid follows fire one cycle later, so a stop seen now blanks the next token.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_link.valid <= 1'b0;
      out_link.data  <= '0;
      err_overflow   <= 1'b0;
    end else begin
      out_link.valid <= fire;
      if (fire) begin
        out_link.data <= pearl_result;
      end
      if (a_overflow || b_overflow) begin
        err_overflow <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_li_shell_join2.sv
// ----------------------------------------------------------------------------
// tb_li_shell_join2 - randomized scoreboard bench for li_shell_join2 (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module tb_li_shell_join2;

  localparam int W     = 6;
  localparam int DEPTH = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] pa;
  logic [W-1:0] pb;
  logic [W-1:0] pres;
  logic         pen;
  logic         err;

  always #5 clk = ~clk;

  li_link #(.WIDTH(W)) la ();
  li_link #(.WIDTH(W)) lb ();
  li_link #(.WIDTH(W)) lo ();

  // Pearl: simple adder tap
  assign pres = pa + pb;

  li_shell_join2 #(
    .WIDTH_A(W), .WIDTH_B(W), .WIDTH_OUT(W), .DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_a_link    (la),
    .in_b_link    (lb),
    .out_link     (lo),
    .pearl_a      (pa),
    .pearl_b      (pb),
    .pearl_en     (pen),
    .pearl_result (pres),
    .err_overflow (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: results expected in order, formed from tokens as issued
  logic [W-1:0] sent_a[$];
  logic [W-1:0] sent_b[$];
  logic [W-1:0] exp_q[$];
  // Occupancy model: contents of each input queue as the protocol defines them
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  bit           prev_fire, exp_stop_a, exp_stop_b, exp_err;
  bit           saw_stop_a, saw_stop_b;
  logic [W-1:0] last_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin : mon
    bit           fire, full_a, full_b;
    logic [W-1:0] dummy;
    if (reset) begin
      qa.delete(); qb.delete(); exp_q.delete(); sent_a.delete(); sent_b.delete();
      prev_fire = 0; exp_stop_a = 0; exp_stop_b = 0; exp_err = 0; last_out = '0;
    end else begin
      fire = (qa.size() > 0) && (qb.size() > 0) && (lo.stop !== 1'b1);
      check("pearl_en", pen, fire);
      if (fire) begin
        check("pearl_a", pa, qa[0]);
        check("pearl_b", pb, qb[0]);
      end
      check("out_valid", lo.valid, prev_fire);
      if (lo.valid === 1'b1) begin
        check("out_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          last_out = exp_q.pop_front();
          check("out_data", lo.data, last_out);
        end
      end else begin
        check("out_hold", lo.data, last_out);
      end
      check("stop_a", la.stop, exp_stop_a);
      check("stop_b", lb.stop, exp_stop_b);
      check("err_overflow", err, exp_err);
      if (la.stop === 1'b1) saw_stop_a = 1;
      if (lb.stop === 1'b1) saw_stop_b = 1;
      full_a = (qa.size() == DEPTH);
      full_b = (qb.size() == DEPTH);
      if (fire) begin
        dummy = qa.pop_front();
        dummy = qb.pop_front();
      end
      if (la.valid === 1'b1) begin
        if (!full_a || fire) qa.push_back(la.data); else exp_err = 1;
      end
      if (lb.valid === 1'b1) begin
        if (!full_b || fire) qb.push_back(lb.data); else exp_err = 1;
      end
      exp_stop_a = (qa.size() >= DEPTH - 1);
      exp_stop_b = (qb.size() >= DEPTH - 1);
      prev_fire  = fire;
    end
  end

  // One cycle of upstream activity; honour=1 obeys the previous cycle's stop.
  task automatic drive_cycle(input bit va, input logic [W-1:0] da, input bit vb,
                             input logic [W-1:0] db, input bit os, input bit honour,
                             output bit oka, output bit okb);
    bit sa, sb;
    logic [W-1:0] r;
    @(negedge clk);
    sa = la.stop;
    sb = lb.stop;
    @(posedge clk);
    #1;
    oka = va && !(honour && sa);
    okb = vb && !(honour && sb);
    la.valid = oka; la.data = da;
    lb.valid = okb; lb.data = db;
    lo.stop  = os;
    if (oka) sent_a.push_back(da);
    if (okb) sent_b.push_back(db);
    while (sent_a.size() > 0 && sent_b.size() > 0) begin
      r = sent_a.pop_front() + sent_b.pop_front();
      exp_q.push_back(r);
    end
  endtask

  task automatic idle(input int n);
    bit oka, okb;
    for (int i = 0; i < n; i++) drive_cycle(0, '0, 0, '0, 0, 1, oka, okb);
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() > 0 && k < 200) begin
      idle(1);
      k++;
    end
    idle(2);
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic stream(input int n, input int pct_a, input int pct_b, input int pct_stop,
                        input bit seq, input int stall_from, input int stall_len);
    int ia = 0, ib = 0, cyc = 0;
    bit wa, wb, os, oka, okb;
    logic [W-1:0] da, db;
    while ((ia < n || ib < n) && cyc < 20000) begin
      wa = (ia < n) && ($urandom_range(0, 99) < pct_a);
      wb = (ib < n) && ($urandom_range(0, 99) < pct_b);
      da = seq ? W'(ia + 1) : W'($urandom_range(0, 63));
      db = seq ? W'(ib + 1) : W'($urandom_range(0, 63));
      os = (cyc >= stall_from && cyc < stall_from + stall_len) ||
           ($urandom_range(0, 99) < pct_stop);
      drive_cycle(wa, da, wb, db, os, 1, oka, okb);
      if (oka) ia++;
      if (okb) ib++;
      cyc++;
    end
    check("stream_complete", (ia >= n) && (ib >= n), 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    la.valid = 1'b0; lb.valid = 1'b0; lo.stop = 1'b0;
    #1;
    check("rst_out_valid", lo.valid, 0);
    check("rst_stop_a", la.stop, 0);
    check("rst_stop_b", lb.stop, 0);
    check("rst_err", err, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit oka, okb;
    la.valid = 0; la.data = '0;
    lb.valid = 0; lb.data = '0;
    lo.stop  = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("init_out_valid", lo.valid, 0);
    check("init_out_data", lo.data, 0);
    check("init_stop_a", la.stop, 0);
    check("init_stop_b", lb.stop, 0);
    check("init_err", err, 0);

    // Join alignment: A early, B three cycles later
    idle(1);
    drive_cycle(1, 6'h11, 0, '0, 0, 1, oka, okb);
    idle(2);
    drive_cycle(0, '0, 1, 6'h22, 0, 1, oka, okb);
    drain();

    // Back-to-back streaming, then a five-cycle output stall mid-stream
    stream(8, 100, 100, 0, 1, 0, 0);
    drain();
    saw_stop_a = 0; saw_stop_b = 0;
    stream(16, 100, 100, 0, 1, 10, 5);
    drain();
    check("stall_stop_a_seen", saw_stop_a, 1);
    check("stall_stop_b_seen", saw_stop_b, 1);

    // Long randomized run with random output back-pressure
    stream(1000, 70, 70, 30, 0, 0, 0);
    drain();
    check("random_no_overflow", err, 0);

    // Overflow: four tokens into A ignoring stop, B idle; fourth is dropped
    do_reset();
    for (int k = 1; k <= 4; k++) drive_cycle(1, W'(k), 0, '0, 0, 0, oka, okb);
    void'(sent_a.pop_back());
    idle(1);
    check("ovf_flag", err, 1);
    check("ovf_head_a", pa, 1);
    for (int k = 1; k <= 3; k++) drive_cycle(0, '0, 1, W'(8 + k), 0, 1, oka, okb);
    drain();
    check("ovf_sticky", err, 1);

    // Reset with tokens queued and an output token in flight
    drive_cycle(1, 6'd5, 1, 6'd6, 0, 0, oka, okb);
    drive_cycle(1, 6'd7, 1, 6'd8, 1, 0, oka, okb);
    drive_cycle(1, 6'd9, 0, '0, 0, 0, oka, okb);
    do_reset();
    stream(20, 80, 80, 20, 0, 0, 0);
    drain();
    check("post_reset_no_overflow", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
